// File: rtl/vz_image_loader.sv
// VZ snapshot loader: parses the 24-byte VZ header from the ioctl download
// stream, writes the payload into system RAM at the header load address and,
// for BASIC images, patches the BASIC start/end pointers. The CPU is held for
// the whole load; done/error are sticky status flags for the OSD/autostart.
module vz_image_loader #(
  parameter logic [7:0]  INDEX     = 8'd1,
  parameter logic [15:0] PTR_START = 16'h78A4,
  parameter logic [15:0] PTR_END   = 16'h78F9
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic [7:0]  dn_index,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  file_type,
  output logic [15:0] start_addr,
  output logic [15:0] end_addr
);

  localparam logic [15:0] HdrLen    = 16'd24;
  localparam logic [7:0]  TypeBasic = 8'hF0;
  localparam logic [7:0]  TypeBin   = 8'hF1;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StData,
    StPatch,
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic        dl_q;
  logic [7:0]  file_type_q, file_type_d;
  logic [15:0] start_q, start_d;
  logic [15:0] end_q, end_d;
  logic [15:0] len_q, len_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  patch_idx_q, patch_idx_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        dl_rise, dl_fall;
  logic        hdr_wr, data_wr, hdr_last, hdr_bad;
  logic [15:0] offset, offset_p1;
  logic [15:0] patch_addr;
  logic [7:0]  patch_data;
  state_e      end_state;

  assign dl_rise   = dn_download & ~dl_q;
  assign dl_fall   = ~dn_download & dl_q;
  assign hdr_wr    = dn_wr && (dn_addr < HdrLen);
  assign data_wr   = dn_wr && (dn_addr >= HdrLen);
  assign hdr_last  = hdr_wr && (dn_addr == 16'd23);
  assign offset    = dn_addr - HdrLen;
  assign offset_p1 = offset + 16'd1;
  // BASIC images need their pointers patched after the payload lands
  assign end_state = (file_type_q == TypeBasic) ? StPatch : StDone;

  // Validate the header byte presented this cycle (magic, version, type)
  always_comb begin
    hdr_bad = 1'b0;
    case (dn_addr)
      16'd0:   hdr_bad = (dn_data != 8'h56);
      16'd1:   hdr_bad = (dn_data != 8'h5A);
      16'd2:   hdr_bad = (dn_data != 8'h46);
      16'd3:   hdr_bad = (dn_data != 8'h30) && (dn_data != 8'h4F);
      16'd21:  hdr_bad = (dn_data != TypeBasic) && (dn_data != TypeBin);
      default: hdr_bad = 1'b0;
    endcase
  end

  // Select the pointer byte written in each PATCH cycle
  always_comb begin
    patch_addr = PTR_START;
    patch_data = start_q[7:0];
    unique case (patch_idx_q)
      2'd0: begin
        patch_addr = PTR_START;
        patch_data = start_q[7:0];
      end
      2'd1: begin
        patch_addr = PTR_START + 16'd1;
        patch_data = start_q[15:8];
      end
      2'd2: begin
        patch_addr = PTR_END;
        patch_data = end_q[7:0];
      end
      2'd3: begin
        patch_addr = PTR_END + 16'd1;
        patch_data = end_q[15:8];
      end
      default: ;
    endcase
  end

  // Next-state logic: header parse, payload writes, pointer patch, status
  always_comb begin
    state_d     = state_q;
    file_type_d = file_type_q;
    start_d     = start_q;
    end_d       = end_q;
    len_d       = len_q;
    mem_addr_d  = mem_addr_q;
    mem_dout_d  = mem_dout_q;
    mem_we_d    = 1'b0;
    patch_idx_d = patch_idx_q;
    done_d      = done_q;
    error_d     = error_q;

    unique case (state_q)
      StHeader: begin
        if (hdr_wr) begin
          if (dn_addr == 16'd21) file_type_d = dn_data;
          if (dn_addr == 16'd22) start_d[7:0] = dn_data;
          if (dn_addr == 16'd23) start_d[15:8] = dn_data;
        end
        if (hdr_wr && hdr_bad) begin
          state_d = StError;
        end else if (hdr_last) begin
          // A fall coinciding with the last header byte is an empty payload
          state_d     = dl_fall ? end_state : StData;
          end_d       = {dn_data, start_q[7:0]};
          len_d       = 16'd0;
          patch_idx_d = 2'd0;
        end else if (dl_fall) begin
          state_d = StError;
        end
      end
      StData: begin
        if (data_wr) begin
          mem_addr_d = start_q + offset;
          mem_dout_d = dn_data;
          mem_we_d   = 1'b1;
          // end_addr follows the highest offset seen, not merely the last one
          if (offset_p1 > len_q) begin
            len_d = offset_p1;
            end_d = start_q + offset_p1;
          end
        end
        if (dl_fall) begin
          state_d     = end_state;
          patch_idx_d = 2'd0;
        end
      end
      StPatch: begin
        mem_addr_d  = patch_addr;
        mem_dout_d  = patch_data;
        mem_we_d    = 1'b1;
        patch_idx_d = patch_idx_q + 2'd1;
        if (patch_idx_q == 2'd3) state_d = StDone;
      end
      default: ;
    endcase

    if (state_d == StDone && state_q != StDone) begin
      done_d  = 1'b1;
      error_d = 1'b0;
    end
    if (state_d == StError && state_q != StError) begin
      done_d  = 1'b0;
      error_d = 1'b1;
    end

    // A new download overrides whatever was in progress
    if (dl_rise) begin
      if (dn_index == INDEX) begin
        state_d     = StHeader;
        done_d      = 1'b0;
        error_d     = 1'b0;
        file_type_d = 8'h00;
        start_d     = 16'h0000;
        end_d       = 16'h0000;
        len_d       = 16'h0000;
      end else begin
        state_d = StIdle;
      end
      mem_we_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= StIdle;
      // Track the live level so a download already running at reset is ignored
      dl_q        <= dn_download;
      file_type_q <= 8'h00;
      start_q     <= 16'h0000;
      end_q       <= 16'h0000;
      len_q       <= 16'h0000;
      mem_addr_q  <= 16'h0000;
      mem_dout_q  <= 8'h00;
      mem_we_q    <= 1'b0;
      patch_idx_q <= 2'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dn_download;
      file_type_q <= file_type_d;
      start_q     <= start_d;
      end_q       <= end_d;
      len_q       <= len_d;
      mem_addr_q  <= mem_addr_d;
      mem_dout_q  <= mem_dout_d;
      mem_we_q    <= mem_we_d;
      patch_idx_q <= patch_idx_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Keep the CPU held until the final registered write has reached RAM
  assign busy = (state_q == StHeader) || (state_q == StData) || (state_q == StPatch) ||
                mem_we_q;
  assign cpu_hold   = busy;
  assign mem_addr   = mem_addr_q;
  assign mem_dout   = mem_dout_q;
  assign mem_we     = mem_we_q;
  assign done       = done_q;
  assign error      = error_q;
  assign file_type  = file_type_q;
  assign start_addr = start_q;
  assign end_addr   = end_q;

endmodule

// File: tb/tb_vz_image_loader.sv
// Scoreboard bench for vz_image_loader: a file-level model pushes the RAM
// writes each download must produce; a negedge monitor pops and compares.
module tb_vz_image_loader;

  localparam logic [7:0] Idx = 8'd1;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dn_download;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [7:0]  dn_index;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  file_type;
  logic [15:0] start_addr;
  logic [15:0] end_addr;

  vz_image_loader dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .dn_download(dn_download),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .dn_index   (dn_index),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .file_type  (file_type),
    .start_addr (start_addr),
    .end_addr   (end_addr)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [7:0]  file_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          quiet = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_error = 1'b0;
  logic [7:0]  exp_type;
  logic [15:0] exp_start;
  logic [15:0] exp_end;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every RAM write must match the next expected one
  always @(negedge clk_sys) begin
    if (mem_we === 1'b1) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("write_data", 32'(mem_dout), 32'(mon_e.data));
      end
      check("hold_during_write", 32'(cpu_hold), 32'd1);
    end
    if (quiet) check("quiet_status", {28'd0, busy, cpu_hold, done, error}, 32'd0);
  end

  // Build a well-formed image; callers may corrupt or override bytes
  task automatic make_file(input logic [7:0] ty, input logic [7:0] ver,
                           input logic [15:0] start, input int len);
    file_q.delete();
    file_q.push_back(8'h56);
    file_q.push_back(8'h5A);
    file_q.push_back(8'h46);
    file_q.push_back(ver);
    for (int i = 0; i < 17; i++) file_q.push_back(8'($urandom_range(32, 126)));
    file_q.push_back(ty);
    file_q.push_back(start[7:0]);
    file_q.push_back(start[15:8]);
    for (int i = 0; i < len; i++) file_q.push_back(8'($urandom));
  endtask

  // Reference model: what a download of the first n bytes must do
  task automatic model_load(input int n, input logic [7:0] idx, output bit valid);
    bit          ok;
    int          len;
    logic [15:0] st;
    valid = 1'b0;
    if (idx != Idx) return;
    ok = (n >= 24) && file_q[0] == 8'h56 && file_q[1] == 8'h5A && file_q[2] == 8'h46 &&
         (file_q[3] == 8'h30 || file_q[3] == 8'h4F) &&
         (file_q[21] == 8'hF0 || file_q[21] == 8'hF1);
    if (!ok) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
      return;
    end
    st  = {file_q[23], file_q[22]};
    len = n - 24;
    for (int i = 0; i < len; i++) exp_q.push_back('{addr: st + 16'(i), data: file_q[24 + i]});
    exp_start = st;
    exp_end   = st + 16'(len);
    exp_type  = file_q[21];
    if (exp_type == 8'hF0) begin
      exp_q.push_back('{addr: 16'h78A4, data: exp_start[7:0]});
      exp_q.push_back('{addr: 16'h78A5, data: exp_start[15:8]});
      exp_q.push_back('{addr: 16'h78F9, data: exp_end[7:0]});
      exp_q.push_back('{addr: 16'h78FA, data: exp_end[15:8]});
    end
    exp_done  = 1'b1;
    exp_error = 1'b0;
    valid     = 1'b1;
  endtask

  task automatic send_bytes(input int from, input int to, input bit coincide, input bit gaps);
    for (int i = from; i < to; i++) begin
      dn_wr   = 1'b1;
      dn_addr = 16'(i);
      dn_data = file_q[i];
      if (coincide && i == to - 1) dn_download = 1'b0;
      @(posedge clk_sys); #1;
      dn_wr = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk_sys);
      #0;
    end
  endtask

  task automatic run_load(input string tag, input int n, input logic [7:0] idx,
                          input bit coincide, input bit gaps);
    bit valid;
    model_load(n, idx, valid);
    dn_index = idx;
    @(posedge clk_sys); #1;
    dn_download = 1'b1;
    @(posedge clk_sys); #1;
    check({tag, "_hold_at_start"}, {30'd0, busy, cpu_hold}, (idx == Idx) ? 32'd3 : 32'd0);
    send_bytes(0, n, coincide, gaps);
    dn_download = 1'b0;
    repeat (10) @(posedge clk_sys);
    #1;
    check({tag, "_busy"}, {30'd0, busy, cpu_hold}, 32'd0);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_error));
    check({tag, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (valid) begin
      check({tag, "_file_type"}, 32'(file_type), 32'(exp_type));
      check({tag, "_start_addr"}, 32'(start_addr), 32'(exp_start));
      check({tag, "_end_addr"}, 32'(end_addr), 32'(exp_end));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {27'd0, mem_we, cpu_hold, busy, done, error}, 32'd0);
    check({tag, "_mem"}, {8'd0, mem_addr, mem_dout}, 32'd0);
    check({tag, "_type"}, 32'(file_type), 32'd0);
    check({tag, "_addrs"}, {start_addr, end_addr}, 32'd0);
  endtask

  initial begin
    logic [7:0]  ty, ver, idx;
    logic [15:0] st;
    int          n, len;

    reset       = 1'b1;
    dn_download = 1'b0;
    dn_wr       = 1'b0;
    dn_addr     = 16'd0;
    dn_data     = 8'd0;
    dn_index    = 8'd0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Wrong index: everything stays quiet
    make_file(8'hF0, 8'h30, 16'h7AE9, 3);
    quiet = 1'b1;
    run_load("wrong_index", file_q.size(), 8'd0, 1'b0, 1'b0);
    quiet = 1'b0;

    // BASIC image
    make_file(8'hF0, 8'h30, 16'h7AE9, 0);
    file_q.push_back(8'h11);
    file_q.push_back(8'h22);
    file_q.push_back(8'h33);
    run_load("basic", file_q.size(), Idx, 1'b0, 1'b0);
    check("basic_end_const", 32'(end_addr), 32'h7AEC);

    // Binary image
    make_file(8'hF1, 8'h4F, 16'h8000, 0);
    file_q.push_back(8'hAA);
    file_q.push_back(8'hBB);
    run_load("binary", file_q.size(), Idx, 1'b0, 1'b0);

    // Bad magic, bad type, truncated header
    make_file(8'hF0, 8'h30, 16'h7AE9, 5);
    file_q[2] = 8'h47;
    run_load("bad_magic", file_q.size(), Idx, 1'b0, 1'b0);
    make_file(8'hF0, 8'h30, 16'h7AE9, 5);
    file_q[21] = 8'hF2;
    run_load("bad_type", file_q.size(), Idx, 1'b0, 1'b0);
    make_file(8'hF1, 8'h30, 16'h7AE9, 5);
    run_load("short", 10, Idx, 1'b0, 1'b0);

    // Address wrap
    make_file(8'hF1, 8'h30, 16'hFFFE, 4);
    run_load("wrap", file_q.size(), Idx, 1'b0, 1'b0);
    check("wrap_end_const", 32'(end_addr), 32'h0002);

    // Reset after two payload bytes, then finish the download
    make_file(8'hF1, 8'h30, 16'h4000, 6);
    exp_q.push_back('{addr: 16'h4000, data: file_q[24]});
    exp_q.push_back('{addr: 16'h4001, data: file_q[25]});
    dn_index = Idx;
    @(posedge clk_sys); #1;
    dn_download = 1'b1;
    @(posedge clk_sys); #1;
    send_bytes(0, 26, 1'b0, 1'b0);
    @(posedge clk_sys); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    send_bytes(26, file_q.size(), 1'b0, 1'b0);
    dn_download = 1'b0;
    repeat (6) @(posedge clk_sys);
    #1;
    check_all_zero("after_reset");
    check("reset_missing_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_done  = 1'b0;
    exp_error = 1'b0;
    make_file(8'hF0, 8'h4F, 16'h7000, 5);
    run_load("post_reset", file_q.size(), Idx, 1'b1, 1'b0);

    // Randomized images, occasionally corrupted, truncated or foreign
    for (int it = 0; it < 16; it++) begin
      ty  = $urandom_range(0, 1) ? 8'hF0 : 8'hF1;
      ver = $urandom_range(0, 1) ? 8'h30 : 8'h4F;
      st  = ($urandom_range(0, 3) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom);
      len = $urandom_range(0, 12);
      make_file(ty, ver, st, len);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0:       file_q[0] = 8'($urandom);
          1:       file_q[1] = 8'($urandom);
          2:       file_q[2] = 8'($urandom);
          3:       file_q[3] = 8'($urandom);
          default: file_q[21] = 8'($urandom);
        endcase
      end
      n   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 23) : file_q.size();
      idx = ($urandom_range(0, 9) == 0) ? 8'd2 : Idx;
      run_load($sformatf("rand%0d", it), n, idx, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      check("done_error_exclusive", 32'(done & error), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vz_image_loader.md
Name: vz_image_loader

Overview:
- Sits between the HPS ioctl download stream and the LASER310 system RAM write port; upstream of the machine core's dn_* memory path.
- Parses a VZ snapshot: 24-byte header, then payload bytes.
- Writes the payload to RAM at the header load address and, for BASIC images, patches the BASIC start/end pointers.
- Holds the CPU for the whole load and reports status for the OSD LED and autostart logic.

Parameters:
- INDEX, 8'd1, ioctl_index value that selects VZ downloads; any other index is ignored.
- PTR_START, 16'h78A4, RAM address of the BASIC program-start pointer (little-endian).
- PTR_END, 16'h78F9, RAM address of the BASIC program-end pointer (little-endian).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- dn_download  in  1  ioctl download active
- dn_wr  in  1  one-cycle strobe; dn_addr/dn_data valid
- dn_addr  in  16  file byte offset
- dn_data  in  8  file byte
- dn_index  in  8  download slot index
- mem_addr  out  16  RAM write address
- mem_dout  out  8  RAM write data
- mem_we  out  1  one-cycle RAM write strobe; RAM always accepts
- cpu_hold  out  1  hold Z80 (WAIT/BUSRQ) while high
- busy  out  1  load in progress
- done  out  1  last load completed OK; sticky
- error  out  1  last load failed; sticky
- file_type  out  8  header type byte (F0 = BASIC, F1 = binary)
- start_addr  out  16  header load address
- end_addr  out  16  start_addr + payload length, exclusive, mod 2^16

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0; start_addr, end_addr and file_type are 0.
  - Reset at any time (including mid-download or mid-PATCH) aborts the load: no further mem_we, cpu_hold drops the next cycle.
- Load start: a rising edge of dn_download while dn_index == INDEX, from any state, moves to HEADER.
  - On entry: clear done/error, set busy and cpu_hold.
  - If dn_index != INDEX, the block stays or returns to IDLE and ignores all traffic.
- HEADER (dn_addr 0..23), capturing on dn_wr; no RAM writes in this state.
  - Bytes 0-2 must be 56 5A 46 ("VZF"). Byte 3 must be 30 or 4F.
  - Bytes 4-20 (name) are ignored.
  - Byte 21 goes to file_type; it must be F0 or F1.
  - Bytes 22/23 go to start_addr low/high.
  - Any check failure: go to ERROR immediately; remaining bytes produce no writes.
  - After byte 23 is accepted: go to DATA, with end_addr = start_addr.
- DATA: on dn_wr with dn_addr >= 24, the next cycle drives:
  - mem_addr = start_addr + (dn_addr - 24), mod 2^16; wrap from FFFF to 0000 is allowed;
  - mem_dout = dn_data;
  - mem_we = 1 for exactly one cycle.
  - end_addr = (dn_addr - 24) + 1 + start_addr, tracking the highest byte written.
  - Latency dn_wr -> mem_we is 1 cycle. Back-to-back dn_wr is supported.
- Download end (dn_download falls):
  - In HEADER, i.e. fewer than 24 bytes received: go to ERROR.
  - In DATA with F1: go to DONE.
  - In DATA with F0: go to PATCH.
  - A zero-length payload is legal: end_addr = start_addr.
- PATCH (BASIC only): four consecutive single-cycle writes, one per clock:
  - PTR_START <- start_addr[7:0]
  - PTR_START+1 <- start_addr[15:8]
  - PTR_END <- end_addr[7:0]
  - PTR_END+1 <- end_addr[15:8]
  - Then go to DONE.
- DONE: busy = 0, cpu_hold = 0, done = 1. Stays until reset or a new load starts.
- ERROR: busy = 0, cpu_hold = 0, error = 1, no writes. Same exit rules as DONE.
- A dn_wr arriving in the same cycle as the dn_download fall is processed before the end-of-download transition.
- A pending DATA write completes before PATCH starts.
- done and error are never high together.

Test Plan:
- BASIC image:
  - Stimulus: header "VZF0", type F0, start 7AE9, 3 payload bytes 11 22 33.
  - Required: writes 7AE9=11, 7AEA=22, 7AEB=33, then 78A4=E9, 78A5=7A, 78F9=EC, 78FA=7A; done=1, end_addr=7AEC.
  - cpu_hold is high from the download rise to the last patch write +1 cycle.
- Binary image:
  - Stimulus: "VZFO", type F1, start 8000, 2 bytes AA BB.
  - Required: writes 8000=AA, 8001=BB only, no patch writes; done=1, file_type=F1.
- Bad input:
  - Magic byte 2 = 47: error=1; zero mem_we for the entire file.
  - Type byte 21 = F2: error=1; zero mem_we.
  - Download ends after 10 bytes: error=1.
- Wrap-around:
  - Stimulus: F1, start FFFE, 4 bytes.
  - Required: writes at FFFE, FFFF, 0000, 0001; end_addr=0002.
- Wrong index:
  - Stimulus: a full valid image downloaded with dn_index=0.
  - Required: no mem_we; busy, cpu_hold, done and error all stay 0.
- Reset mid-load:
  - Stimulus: assert reset after 2 payload bytes, then complete the download.
  - Required: no writes after reset; all outputs 0.
  - A subsequent valid load then completes with done=1.
